// File: rtl/adder_sum_accumulator_pkg.sv
// adder_sum_accumulator_pkg
//   Shared constants for the adder stage and its downstream sum accumulator:
//   default operand/accumulator/count widths and the accumulator FSM state
//   encodings.
//   Optional feature macro used by the accumulator datapath: SATURATE_EN.
package adder_sum_accumulator_pkg;

  // Adder operand width; the adder stage emits NBIT+1-bit sums.
  localparam int NBIT_DEF  = 8;
  // Accumulator width; must be at least NBIT+1.
  localparam int ACC_W_DEF = 16;
  // Beat-count field width; the longest job is 2^CNT_W-1 sums.
  localparam int CNT_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// adder_sum_accumulator_if
//   Bundles the job request, the sum-input valid/ready channel and the
//   total-output valid/ready channel of the sum accumulator.
//   master : job/stream producer and result consumer
//            (drives start, len, s_in, s_valid, out_ready)
//   slave  : the accumulator
//            (drives s_ready, acc_out, out_valid, busy, ovf)
//   Optional feature macro affecting the slave: SATURATE_EN (no effect here).
interface adder_sum_accumulator_if
  import adder_sum_accumulator_pkg::*;
#(
  parameter int NBIT  = NBIT_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic [NBIT:0]    s_in;
  logic             s_valid;
  logic             s_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start,
    output len,
    output s_in,
    output s_valid,
    input  s_ready,
    input  acc_out,
    input  out_valid,
    output out_ready,
    input  busy,
    input  ovf
  );

  modport slave (
    input  start,
    input  len,
    input  s_in,
    input  s_valid,
    output s_ready,
    output acc_out,
    output out_valid,
    input  out_ready,
    output busy,
    output ovf
  );

endinterface

// File: rtl/adder_sum_accumulator_acc_sat_add.sv
// adder_sum_accumulator_acc_sat_add
//   Combinational accumulate step: acc + addend with carry out.
//   Ports:
//     acc_i    [ACC_W-1:0]  current accumulator value
//     addend_i [ACC_W-1:0]  zero-extended sum from the adder stage
//     sum_o    [ACC_W-1:0]  next accumulator value
//     carry_o               carry out of the ACC_W-bit add
//   Optional feature macro: SATURATE_EN
//     defined   : on carry out, sum_o clamps to all ones
//     undefined : sum_o wraps modulo 2^ACC_W
module adder_sum_accumulator_acc_sat_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] addend_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] raw_sum;

  always_comb begin
    raw_sum = {1'b0, acc_i} + {1'b0, addend_i};
    carry_o = raw_sum[ACC_W];
`ifdef SATURATE_EN
    // Once clamped, every later non-zero addend carries again, so the
    // accumulator stays pinned at full scale for the rest of the job.
    sum_o = raw_sum[ACC_W] ? '1 : raw_sum[ACC_W-1:0];
`else
    sum_o = raw_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//   Accepts a programmed number of NBIT+1-bit sums from the adder stage over a
//   valid/ready channel, accumulates them into an ACC_W-bit register and
//   presents the total over a second valid/ready channel.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   adder_sum_accumulator_if.slave
//           start/len   job request, sampled only in IDLE
//           s_in/s_valid/s_ready      sum input channel
//           acc_out/out_valid/out_ready total output channel
//           busy        high in ACCUM or DONE
//           ovf         sticky per-job carry-out flag
//   Optional feature macro: SATURATE_EN (clamp instead of wrap on overflow,
//   implemented in adder_sum_accumulator_acc_sat_add).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; s_ready low
//   ST_ACCUM | taking sums; count_q holds beats still to come
//   ST_DONE  | out_valid high, acc_out held until out_ready
module adder_sum_accumulator
  import adder_sum_accumulator_pkg::*;
#(
  parameter int NBIT  = NBIT_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  adder_sum_accumulator_if.slave bus
);

  if (ACC_W < NBIT + 1) begin : g_bad_width
    $error("ACC_W must be at least NBIT+1");
  end

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q,   ovf_d;

  logic             beat;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign beat   = bus.s_valid && (state_q == ST_ACCUM);
  assign addend = ACC_W'(bus.s_in);

  adder_sum_accumulator_acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_acc_sat_add (
    .acc_i    (acc_q),
    .addend_i (addend),
    .sum_o    (add_sum),
    .carry_o  (add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            count_d = bus.len;
            state_d = ST_ACCUM;
          end else begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_carry;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A simultaneous start is dropped; the next job needs a fresh IDLE cycle.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.s_ready   = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb_adder_sum_accumulator
//   Drives two accumulators (ACC_W=16 and ACC_W=10, NBIT=8, CNT_W=4) with the
//   same job stream. A job-level model tracks the phase and the exact integer
//   total of each job; expected totals are derived from that total by plain
//   modular/clamp arithmetic. Literal totals pin the model on every job.
//   Optional feature macro: SATURATE_EN (changes the expected ACC_W=10 totals).
module tb_adder_sum_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [8:0] s_in;
  logic       s_valid;
  logic       out_ready;

  adder_sum_accumulator_if #(.NBIT(8), .ACC_W(16), .CNT_W(4)) if16 ();
  adder_sum_accumulator_if #(.NBIT(8), .ACC_W(10), .CNT_W(4)) if10 ();

  assign if16.start     = start;
  assign if16.len       = len;
  assign if16.s_in      = s_in;
  assign if16.s_valid   = s_valid;
  assign if16.out_ready = out_ready;
  assign if10.start     = start;
  assign if10.len       = len;
  assign if10.s_in      = s_in;
  assign if10.s_valid   = s_valid;
  assign if10.out_ready = out_ready;

  adder_sum_accumulator #(.NBIT(8), .ACC_W(16), .CNT_W(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  adder_sum_accumulator #(.NBIT(8), .ACC_W(10), .CNT_W(4)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (if10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- job-level model ----------------
  // phase: 0 waiting for a job, 1 collecting sums, 2 presenting the total
  int     m_phase;
  int     m_left;
  longint m_total;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_total = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_total = 0;
          m_left  = int'(len);
          m_phase = (len == 0) ? 2 : 1;
        end
        1: if (s_valid) begin
          m_total = m_total + longint'(s_in);
          m_left  = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  function automatic longint exp_acc(input longint total, input int w);
    longint full;
    full = (longint'(1) << w) - 1;
`ifdef SATURATE_EN
    return (total > full) ? full : total;
`else
    return total % (full + 1);
`endif
  endfunction

  function automatic longint exp_ovf(input longint total, input int w);
    return (total > ((longint'(1) << w) - 1)) ? 1 : 0;
  endfunction

  // ---------------- compare process ----------------
  int     total;
  int     bad;
  logic   chk_en;
  logic   lit_on;
  longint lit_acc16, lit_ovf16, lit_acc10, lit_ovf10;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input int w, input logic s_ready_v,
                         input logic out_valid_v, input logic busy_v,
                         input longint acc_v, input logic ovf_v);
    if (rst) begin
      chk({tag, "_rst_s_ready"},   s_ready_v,   0);
      chk({tag, "_rst_out_valid"}, out_valid_v, 0);
      chk({tag, "_rst_busy"},      busy_v,      0);
      chk({tag, "_rst_acc_out"},   acc_v,       0);
      chk({tag, "_rst_ovf"},       ovf_v,       0);
    end else begin
      chk({tag, "_s_ready"},   s_ready_v,   (m_phase == 1) ? 1 : 0);
      chk({tag, "_out_valid"}, out_valid_v, (m_phase == 2) ? 1 : 0);
      chk({tag, "_busy"},      busy_v,      (m_phase != 0) ? 1 : 0);
      if (m_phase == 2) begin
        chk({tag, "_acc_out"}, acc_v, exp_acc(m_total, w));
        chk({tag, "_ovf"},     ovf_v, exp_ovf(m_total, w));
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("d16", 16, if16.s_ready, if16.out_valid, if16.busy,
              longint'(if16.acc_out), if16.ovf);
      cmp_dut("d10", 10, if10.s_ready, if10.out_valid, if10.busy,
              longint'(if10.acc_out), if10.ovf);
      if (lit_on && !rst) begin
        chk("lit_d16_valid", if16.out_valid, 1);
        chk("lit_d16_acc",   longint'(if16.acc_out), lit_acc16);
        chk("lit_d16_ovf",   if16.ovf, lit_ovf16);
        chk("lit_d10_valid", if10.out_valid, 1);
        chk("lit_d10_acc",   longint'(if10.acc_out), lit_acc10);
        chk("lit_d10_ovf",   if10.ovf, lit_ovf10);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l);
    start = 1'b1;
    len   = 4'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int v, input int gap);
    s_valid = 1'b1;
    s_in    = 9'(v);
    tick();
    s_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic lit(input longint a16, input longint o16,
                     input longint a10, input longint o10);
    lit_acc16 = a16;
    lit_ovf16 = o16;
    lit_acc10 = a10;
    lit_ovf10 = o10;
    lit_on    = 1'b1;
  endtask

  task automatic finish_out(input int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    lit_on    = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    chk_en    = 1'b0;
    lit_on    = 1'b0;
    lit_acc16 = 0;
    lit_ovf16 = 0;
    lit_acc10 = 0;
    lit_ovf10 = 0;
    rst       = 1'b0;
    start     = 1'b0;
    len       = '0;
    s_in      = '0;
    s_valid   = 1'b0;
    out_ready = 1'b0;

    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // basic job, continuous stream
    start_job(4);
    beat(3, 0); beat(7, 0); beat(16, 0); beat(66, 0);
    lit(92, 0, 92, 0);
    finish_out(0);
    tick();

    // gaps between beats, consumer stalls 3 cycles
    start_job(4);
    beat(3, 2); beat(7, 2); beat(16, 2); beat(66, 0);
    lit(92, 0, 92, 0);
    finish_out(3);
    tick();

    // zero-length job
    start_job(0);
    lit(0, 0, 0, 0);
    finish_out(1);
    tick();

    // overflow of the narrow accumulator
    start_job(5);
    for (int i = 0; i < 5; i++) beat(510, 0);
`ifdef SATURATE_EN
    lit(2550, 0, 1023, 1);
`else
    lit(2550, 0, 502, 1);
`endif
    finish_out(0);
    tick();

    // start held during ACCUM and DONE is ignored; new job clears ovf
    start_job(2);
    start = 1'b1;
    len   = 4'd7;
    beat(3, 0);
    beat(7, 0);
    lit(10, 0, 10, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    lit_on    = 1'b0;
    tick();
    tick();

    // longest job with full-scale sums
    start_job(15);
    for (int i = 0; i < 15; i++) beat(511, 0);
`ifdef SATURATE_EN
    lit(7665, 0, 1023, 1);
`else
    lit(7665, 0, 497, 1);
`endif
    finish_out(1);
    tick();

    // reset in the middle of a job
    start_job(4);
    beat(3, 0);
    beat(7, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start_job(1);
    beat(165, 0);
    lit(165, 0, 165, 0);
    finish_out(0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
